// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// rtl/hazard_scoreboard_ctrl_pkg.sv - shared types and constants for the hazard scoreboard
// Purpose: scoreboard entry layout, x0 address and default geometry.
// Ports: none (package hazard_pkg).
package hazard_pkg;

  localparam int REG_W_DEF = 5;
  localparam int DEPTH_DEF = 3;

  localparam logic [REG_W_DEF-1:0] X0_ADDR = '0;

  // One in-flight instruction: entry 0 is EX, entry DEPTH-1 is WB.
  typedef struct packed {
    logic                 valid;
    logic [REG_W_DEF-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// rtl/hazard_scoreboard_ctrl_if.sv - ID-stage operand / pipeline control bundle
// Purpose: groups the ID-stage decode fields, the EX flush request and the
//          returned stall/bubble/flush controls.
// Ports (signals): id_valid, rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id,
//          regwrite_id, memread_id, flush_ex (pipeline -> controller);
//          stall_if, stall_id, bubble_ex, flush_id (controller -> pipeline).
// Modports: master = pipeline side, slave = hazard controller.
interface hazard_scoreboard_ctrl_if #(
  parameter int REG_W = hazard_pkg::REG_W_DEF
);

  logic             id_valid;
  logic [REG_W-1:0] rs1_id;
  logic [REG_W-1:0] rs2_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic [REG_W-1:0] rd_id;
  logic             regwrite_id;
  logic             memread_id;
  logic             flush_ex;
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             flush_id;

  modport master (
    output id_valid, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           rd_id, regwrite_id, memread_id, flush_ex,
    input  stall_if, stall_id, bubble_ex, flush_id
  );

  modport slave (
    input  id_valid, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           rd_id, regwrite_id, memread_id, flush_ex,
    output stall_if, stall_id, bubble_ex, flush_id
  );

endinterface

// File: rtl/hazard_scoreboard_ctrl_match.sv
// rtl/hazard_scoreboard_ctrl_match.sv - per-entry RAW comparator
// Purpose: flags a read-after-write conflict between the ID sources and one
//          scoreboard entry; x0 and unused sources never match.
// Ports: entry (scoreboard entry), rs1/rs2 (ID sources), rs1_used/rs2_used,
//        match (conflict flag).
module hazard_match
  import hazard_pkg::*;
(
  input  sb_entry_t            entry,
  input  logic [REG_W_DEF-1:0] rs1,
  input  logic [REG_W_DEF-1:0] rs2,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  output logic                 match
);

  logic src_hit;

  assign src_hit = (rs1_used && (rs1 == entry.rd)) || (rs2_used && (rs2 == entry.rd));
  assign match   = entry.valid && entry.regwrite && (entry.rd != X0_ADDR) && src_hit;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - in-order RAW hazard controller for a 5-stage pipeline
// Purpose: tracks destinations of the EX/MEM/WB instructions in a shift-register
//          scoreboard and raises IF/ID stall, EX bubble and ID flush.
// Ports: clk; rst (synchronous, active-low); hz (slave modport of
//        hazard_scoreboard_ctrl_if); stall_cycles (saturating count of stalled
//        cycles); deadlock_err (sticky, stall run longer than DEPTH cycles).
// Config: FORWARDING_EN - bypass network present, only a load in EX stalls ID.
module hazard_scoreboard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_scoreboard_ctrl_if.slave   hz,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic                      deadlock_err
);

  localparam logic [2:0] RUN_LIMIT = 3'(DEPTH);

  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             new_entry;
  logic [DEPTH-1:0]      match;
  logic [REG_W-1:0]      rs1, rs2, rd;
  logic                  hazard, stall, issue;
  logic [2:0]            run_cnt;

  assign rs1 = hz.rs1_id;
  assign rs2 = hz.rs2_id;
  assign rd  = hz.rd_id;

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    hazard_match u_match (
      .entry    (sb[g]),
      .rs1      (rs1),
      .rs2      (rs2),
      .rs1_used (hz.rs1_used_id),
      .rs2_used (hz.rs2_used_id),
      .match    (match[g])
    );
  end

`ifdef FORWARDING_EN
  // Results in EX/MEM are bypassed; only load data is not ready yet.
  assign hazard = match[0] && sb[0].memread;
`else
  // No bypass and no regfile write-through: any in-flight writer conflicts.
  assign hazard = |match;
`endif

  // rst gates the stall so a reset mid-stall drops it in the same cycle.
  assign stall = rst && hz.id_valid && hazard && !hz.flush_ex;
  assign issue = hz.id_valid && !stall && !hz.flush_ex;

  assign hz.stall_if  = stall;
  assign hz.stall_id  = stall;
  assign hz.bubble_ex = stall || hz.flush_ex || !rst;
  assign hz.flush_id  = hz.flush_ex && rst;

  always_comb begin
    new_entry = '0;
    if (issue) begin
      new_entry.valid    = 1'b1;
      new_entry.rd       = rd;
      new_entry.regwrite = hz.regwrite_id;
      new_entry.memread  = hz.memread_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb           <= '0;
      stall_cycles <= '0;
      run_cnt      <= '0;
      deadlock_err <= 1'b0;
    end else begin
      sb <= {sb[DEPTH-2:0], new_entry};
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (stall) begin
        if (run_cnt != 3'h7) begin
          run_cnt <= run_cnt + 3'd1;
        end
        // run_cnt counts earlier stall cycles of this run; reaching DEPTH
        // here means the current cycle is the (DEPTH+1)-th in a row.
        if (run_cnt >= RUN_LIMIT) begin
          deadlock_err <= 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb/tb_hazard_scoreboard_ctrl.sv - self-checking bench for hazard_scoreboard_ctrl
// Purpose: directed vector table plus chain, saturation and watchdog sequences.
// Ports: none. Honours FORWARDING_EN.
module tb_hazard_scoreboard_ctrl;
  import hazard_pkg::*;

`ifdef FORWARDING_EN
  localparam int S = 1;
`else
  localparam int S = 3;
`endif
  localparam int N_DEP = 21;

  typedef struct {
    logic       r;
    logic       v;
    logic [4:0] a;
    logic [4:0] b;
    logic       ua;
    logic       ub;
    logic [4:0] d;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       es;
    logic       eb;
    logic       ef;
    int         ec;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  logic        err_a, err_b;
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl_if #(.REG_W(5)) ifa ();
  hazard_scoreboard_ctrl_if #(.REG_W(5)) ifb ();

  assign ifb.id_valid    = ifa.id_valid;
  assign ifb.rs1_id      = ifa.rs1_id;
  assign ifb.rs2_id      = ifa.rs2_id;
  assign ifb.rs1_used_id = ifa.rs1_used_id;
  assign ifb.rs2_used_id = ifa.rs2_used_id;
  assign ifb.rd_id       = ifa.rd_id;
  assign ifb.regwrite_id = ifa.regwrite_id;
  assign ifb.memread_id  = ifa.memread_id;
  assign ifb.flush_ex    = ifa.flush_ex;

  hazard_scoreboard_ctrl #(.REG_W(5), .DEPTH(3), .CNT_W(32)) dut_a (
    .clk          (clk),
    .rst          (rst_n),
    .hz           (ifa),
    .stall_cycles (cnt_a),
    .deadlock_err (err_a)
  );

  hazard_scoreboard_ctrl #(.REG_W(5), .DEPTH(3), .CNT_W(4)) dut_b (
    .clk          (clk),
    .rst          (rst_n),
    .hz           (ifb),
    .stall_cycles (cnt_b),
    .deadlock_err (err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic ua, input logic ub, input logic [4:0] d,
                       input logic rw, input logic mr, input logic fl);
    rst_n           = r;
    ifa.id_valid    = v;
    ifa.rs1_id      = a;
    ifa.rs2_id      = b;
    ifa.rs1_used_id = ua;
    ifa.rs2_used_id = ub;
    ifa.rd_id       = d;
    ifa.regwrite_id = rw;
    ifa.memread_id  = mr;
    ifa.flush_ex    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic v, logic [4:0] a, logic [4:0] b, logic ua, logic ub,
                              logic [4:0] d, logic rw, logic mr, logic fl,
                              logic es, logic eb, logic ef, int ec);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.b = b; t.ua = ua; t.ub = ub; t.d = d;
    t.rw = rw; t.mr = mr; t.fl = fl; t.es = es; t.eb = eb; t.ef = ef; t.ec = ec;
    return t;
  endfunction

  initial begin
    sb_entry_t ent;
    logic [4:0] prev, rdi;

`ifdef FORWARDING_EN
    tbl.push_back(mk(0, 1,  1, 0, 1, 0,  7, 1, 1, 0,  0, 1, 0, 0));
    tbl.push_back(mk(1, 1,  1, 0, 1, 0,  7, 1, 1, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 1,  7, 1, 1, 1,  8, 1, 0, 0,  1, 1, 0, 0));
    tbl.push_back(mk(1, 1,  7, 1, 1, 1,  8, 1, 0, 0,  0, 0, 0, 1));
    tbl.push_back(mk(1, 1,  8, 1, 1, 1,  9, 1, 0, 0,  0, 0, 0, 1));
    tbl.push_back(mk(1, 1,  1, 0, 1, 0,  0, 1, 1, 0,  0, 0, 0, 1));
    tbl.push_back(mk(1, 1,  0, 0, 1, 0, 12, 1, 0, 0,  0, 0, 0, 1));
    tbl.push_back(mk(1, 1,  1, 0, 1, 0, 13, 1, 1, 0,  0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 13, 0, 1, 0, 14, 1, 0, 1,  0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 13, 0, 1, 0, 14, 1, 0, 0,  0, 0, 0, 1));
    tbl.push_back(mk(1, 0,  0, 0, 0, 0,  0, 0, 0, 1,  0, 1, 1, 1));
`else
    tbl.push_back(mk(0, 1,  1, 2, 1, 1,  5, 1, 0, 0,  0, 1, 0, 0));
    tbl.push_back(mk(1, 1,  1, 2, 1, 1,  5, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 1,  5, 3, 1, 1,  6, 1, 0, 0,  1, 1, 0, 0));
    tbl.push_back(mk(1, 1,  5, 3, 1, 1,  6, 1, 0, 0,  1, 1, 0, 1));
    tbl.push_back(mk(1, 1,  5, 3, 1, 1,  6, 1, 0, 0,  1, 1, 0, 2));
    tbl.push_back(mk(1, 1,  5, 3, 1, 1,  6, 1, 0, 0,  0, 0, 0, 3));
    tbl.push_back(mk(1, 0,  6, 0, 1, 0,  7, 1, 0, 0,  0, 0, 0, 3));
    tbl.push_back(mk(1, 1,  1, 0, 1, 0,  0, 1, 0, 0,  0, 0, 0, 3));
    tbl.push_back(mk(1, 1,  0, 0, 1, 1,  2, 1, 0, 0,  0, 0, 0, 3));
    tbl.push_back(mk(1, 1,  2, 0, 0, 0,  9, 1, 0, 0,  0, 0, 0, 3));
    tbl.push_back(mk(1, 1,  9, 0, 1, 0,  3, 1, 0, 1,  0, 1, 1, 3));
    tbl.push_back(mk(1, 1,  3, 0, 1, 0,  4, 1, 0, 0,  0, 0, 0, 3));
    tbl.push_back(mk(1, 1,  9, 0, 1, 0, 10, 1, 0, 0,  1, 1, 0, 3));
    tbl.push_back(mk(1, 1,  9, 0, 1, 0, 10, 1, 0, 0,  0, 0, 0, 4));
    tbl.push_back(mk(1, 1, 10, 0, 1, 0, 11, 1, 0, 0,  1, 1, 0, 4));
    tbl.push_back(mk(0, 1, 10, 0, 1, 0, 11, 1, 0, 0,  0, 1, 0, 5));
    tbl.push_back(mk(1, 1, 10, 0, 1, 0, 11, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0,  0, 0, 0, 0,  0, 0, 0, 1,  0, 1, 1, 0));
`endif

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      tick();
      drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].ua, tbl[i].ub,
            tbl[i].d, tbl[i].rw, tbl[i].mr, tbl[i].fl);
      #1;
      check($sformatf("row%0d stall_id", i),  32'(ifa.stall_id),  32'(tbl[i].es));
      check($sformatf("row%0d stall_if", i),  32'(ifa.stall_if),  32'(tbl[i].es));
      check($sformatf("row%0d bubble_ex", i), 32'(ifa.bubble_ex), 32'(tbl[i].eb));
      check($sformatf("row%0d flush_id", i),  32'(ifa.flush_id),  32'(tbl[i].ef));
      check($sformatf("row%0d stall_cycles", i), cnt_a, 32'(tbl[i].ec));
      check($sformatf("row%0d deadlock_err", i), 32'(err_a), 32'd0);
    end

    // Dependent load chain: each link stalls S cycles, then issues.
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 0, 1, 0, 16, 1, 1, 0);
    #1;
    check("chain head stall", 32'(ifa.stall_id), 32'd0);
    prev = 5'd16;
    for (int i = 1; i <= N_DEP; i++) begin
      rdi = 5'(16 + (i % 8));
      for (int k = 0; k <= S; k++) begin
        tick();
        drive(1, 1, prev, 0, 1, 0, rdi, 1, 1, 0);
        #1;
        check($sformatf("chain%0d cyc%0d stall", i, k), 32'(ifa.stall_id), 32'(k < S));
      end
      prev = rdi;
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("chain stall_cycles", cnt_a, 32'(N_DEP * S));
    check("cnt4 saturated", 32'(cnt_b), 32'd15);
    check("chain no deadlock a", 32'(err_a), 32'd0);
    check("chain no deadlock b", 32'(err_b), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("cnt4 held", 32'(cnt_b), 32'd15);

    // Watchdog: pin the scoreboard so the conflict never drains.
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ent.valid = 1'b1; ent.rd = 5'd5; ent.regwrite = 1'b1; ent.memread = 1'b1;
    force dut_a.sb = {3{ent}};
    for (int c = 1; c <= 5; c++) begin
      tick();
      drive(1, 1, 5, 0, 1, 0, 6, 1, 0, 0);
      #1;
      check($sformatf("wdog cyc%0d stall", c), 32'(ifa.stall_id), 32'd1);
      check($sformatf("wdog cyc%0d err", c), 32'(err_a), 32'(c == 5));
    end
    tick();
    release dut_a.sb;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("wdog sticky", 32'(err_a), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("wdog cleared by reset", 32'(err_a), 32'd0);
    check("cnt cleared by reset", cnt_a, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
